// File: rtl/adf_cfg_seq.sv
// Serial configuration sequencer: shadow register file streamed MSB first over sclk/sdata/le.
// Pending registers are sent highest index first; each word is latched by an le pulse held for LE_HIGH sclk periods.
module adf_cfg_seq #(
    parameter int NUM_REGS = 10,
    parameter int REG_W    = 32,
    parameter int CLK_DIV  = 1,
    parameter int LE_HIGH  = 2,
    parameter int EN_REG   = 0,
    parameter int EN_BIT   = 31,
    parameter logic [NUM_REGS*REG_W-1:0] INIT = '0,
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [REG_W-1:0] cfg_wdata,
    input  logic             cfg_send,
    input  logic             start,
    input  logic             enable,
    output logic             busy,
    output logic             config_done,
    output logic             sclk,
    output logic             sdata,
    output logic             le,
    output logic             ce
);

    localparam int HOLD_N = 2 * CLK_DIV * LE_HIGH;
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
    localparam int HW     = (HOLD_N > 1) ? $clog2(HOLD_N + 1) : 1;
    localparam int BW     = $clog2(REG_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, HOLD} state_t;

    state_t             state;
    logic [REG_W-1:0]   shadow [NUM_REGS];
    logic [NUM_REGS-1:0] mask, mask_set, mask_n;
    logic [AW-1:0]      sel, cur;
    logic               configured, seq_active, en_sent;
    logic [REG_W-1:0]   shreg, load_word;
    logic [DW-1:0]      div_cnt;
    logic [BW-1:0]      rise_cnt;
    logic [HW-1:0]      hold_cnt;
    logic               addr_ok, div_tick, hold_done, en_chg, conf_n, idle_n;

    assign addr_ok   = int'(cfg_addr) < NUM_REGS;
    assign div_tick  = div_cnt == DW'(CLK_DIV - 1);
    assign hold_done = hold_cnt == HW'(HOLD_N - 1);
    // The enable word's own LOAD cycle is excluded so the sample it takes does not re-queue it.
    assign en_chg    = configured && (enable != en_sent) && !(state == LOAD && int'(cur) == EN_REG);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (mask[i]) sel = AW'(i);
        end
    end

    always_comb begin
        mask_set = '0;
        if (ce) begin
            if (start) mask_set = '1;
            if (cfg_we && cfg_send && addr_ok && configured) mask_set[cfg_addr] = 1'b1;
            if (en_chg) mask_set[EN_REG] = 1'b1;
        end
        mask_n = mask | mask_set;
        if (state == IDLE && mask != '0) mask_n[sel] = 1'b0;
    end

    always_comb begin
        load_word = shadow[cur];
        if (int'(cur) == EN_REG) load_word[EN_BIT] = enable;
    end

    assign idle_n = (state == IDLE && mask == '0) || (state == HOLD && hold_done);
    assign conf_n = configured ||
                    (state == HOLD && hold_done && seq_active && cur == '0 && mask_n == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= INIT[i*REG_W +: REG_W];
        end else if (cfg_we && addr_ok) begin
            shadow[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mask        <= '0;
            cur         <= '0;
            configured  <= 1'b0;
            seq_active  <= 1'b0;
            en_sent     <= 1'b0;
            shreg       <= '0;
            div_cnt     <= '0;
            rise_cnt    <= '0;
            hold_cnt    <= '0;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            le          <= 1'b1;
            ce          <= 1'b0;
            busy        <= 1'b0;
            config_done <= 1'b0;
        end else begin
            ce          <= 1'b1;
            mask        <= mask_n;
            configured  <= conf_n;
            config_done <= conf_n && (mask_n == '0) && idle_n;
            if (ce && start)
                seq_active <= 1'b1;
            else if (conf_n && !configured)
                seq_active <= 1'b0;

            case (state)
                IDLE: begin
                    if (mask != '0) begin
                        cur   <= sel;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg    <= load_word;
                    sdata    <= load_word[REG_W-1];
                    sclk     <= 1'b0;
                    le       <= 1'b0;
                    div_cnt  <= '0;
                    rise_cnt <= '0;
                    if (int'(cur) == EN_REG) en_sent <= enable;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk     <= 1'b1;
                            rise_cnt <= rise_cnt + 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (rise_cnt == BW'(REG_W)) begin
                                le       <= 1'b1;
                                hold_cnt <= '0;
                                state    <= HOLD;
                            end else begin
                                sdata <= shreg[REG_W-2];
                                shreg <= {shreg[REG_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        le    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
